// File: rtl/drm_pkg.sv
// Shared types and widths for the SDRAM capture path.
package drm_pkg;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 16;
  localparam int SDRAM_BE_W   = SDRAM_DATA_W / 8;
  localparam int FIFO_W       = SDRAM_DATA_W + SDRAM_BE_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } cap_state_t;

  // One queued SDRAM word: byte enables travel with the data.
  typedef struct packed {
    logic [SDRAM_BE_W-1:0]   be;
    logic [SDRAM_DATA_W-1:0] data;
  } fifo_word_t;

endpackage

// File: rtl/capture_word_fifo.sv
// Word FIFO between the byte packer and the Avalon write port.
// A push into a full FIFO is still taken when a pop happens in the same cycle.
module capture_word_fifo
  import drm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = FIFO_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             M100CLK,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  output logic             push_ok,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_ok;

  // Accept/pop qualification from the registered occupancy.
  always_comb begin
    pop_ok  = pop && (count != '0);
    push_ok = push && ((count != DEPTH_C) || pop_ok);
  end

  assign head = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge M100CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_capture_writer.sv
// Packs ADC bytes into 16-bit words and streams them to SDRAM over Avalon-MM.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for arm; outputs quiet
// ST_CAPTURE | packing samples into words and writing them out
// ST_DRAIN   | arm dropped; flushing FIFO, new samples and arm ignored
module sdram_capture_writer
  import drm_pkg::*;
#(
  parameter logic [SDRAM_ADDR_W-1:0] BASE_ADDR  = 25'h0000000,
  parameter logic [SDRAM_ADDR_W-1:0] ADDR_LIMIT = 25'h1FFFFFF,
  parameter int                      DEPTH      = 16
) (
  input  logic                    M100CLK,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    sample_valid,
  input  logic [7:0]              sample,
  output logic                    av_chipselect,
  output logic [SDRAM_ADDR_W-1:0] av_address,
  output logic [SDRAM_BE_W-1:0]   av_byteenable,
  output logic [SDRAM_DATA_W-1:0] av_writedata,
  output logic                    av_write,
  input  logic                    av_waitrequest,
  output logic                    busy,
  output logic                    overflow,
  output logic                    wrapped,
  output logic [SDRAM_ADDR_W-1:0] words_written
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  cap_state_t       state;
  logic             half_valid;
  logic [7:0]       half_byte;
  logic             arm_start;
  logic             pair_push;
  logic             pad_push;
  logic             push;
  logic             push_ok;
  logic             wr_accept;
  fifo_word_t       push_word;
  fifo_word_t       head_word;
  logic [CNT_W-1:0] fifo_count;

  // Push sources: a completed pair while armed, or the lone byte left when arm drops.
  always_comb begin
    arm_start      = (state == ST_IDLE) && arm;
    pair_push      = (state == ST_CAPTURE) && arm && sample_valid && half_valid;
    pad_push       = (state == ST_CAPTURE) && !arm && half_valid;
    push           = pair_push || pad_push;
    push_word.data = pad_push ? {8'h00, half_byte} : {sample, half_byte};
    push_word.be   = pad_push ? 2'b01 : 2'b11;
  end

  capture_word_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .M100CLK   (M100CLK),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .push_ok   (push_ok),
    .pop       (wr_accept),
    .head      (head_word),
    .count     (fifo_count)
  );

  // Avalon port is driven straight from the FIFO head so it stays stable under waitrequest.
  always_comb begin
    av_write      = (fifo_count != '0);
    av_chipselect = av_write;
    av_writedata  = av_write ? head_word.data : '0;
    av_byteenable = av_write ? head_word.be : '0;
    wr_accept     = av_write && !av_waitrequest;
  end

  // Sequencer and byte packer.
  always_ff @(posedge M100CLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      half_valid <= 1'b0;
      half_byte  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state      <= ST_CAPTURE;
            busy       <= 1'b1;
            half_valid <= 1'b0;
            half_byte  <= '0;
          end
        end
        ST_CAPTURE: begin
          if (!arm) begin
            state      <= ST_DRAIN;
            half_valid <= 1'b0;
          end else if (sample_valid) begin
            if (half_valid) begin
              half_valid <= 1'b0;
            end else begin
              half_valid <= 1'b1;
              half_byte  <= sample;
            end
          end
        end
        ST_DRAIN: begin
          if ((fifo_count == '0) && !half_valid) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Address, word count and sticky status, all restarted on each new arm.
  always_ff @(posedge M100CLK) begin
    if (reset || arm_start) begin
      av_address    <= BASE_ADDR;
      words_written <= '0;
      wrapped       <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (wr_accept) begin
        if (av_address == ADDR_LIMIT) begin
          av_address <= BASE_ADDR;
          wrapped    <= 1'b1;
        end else begin
          av_address <= av_address + SDRAM_ADDR_W'(1);
        end
        if (words_written != '1) begin
          words_written <= words_written + SDRAM_ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_capture_writer.sv
// Scoreboard bench for sdram_capture_writer with a small FIFO and a short address window.
module tb_sdram_capture_writer;

  localparam logic [24:0] BASE  = 25'h0000000;
  localparam logic [24:0] LIMIT = 25'h0000003;
  localparam int          DEPTH = 4;

  logic        M100CLK = 1'b0;
  logic        reset;
  logic        arm;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        av_chipselect;
  logic [24:0] av_address;
  logic [1:0]  av_byteenable;
  logic [15:0] av_writedata;
  logic        av_write;
  logic        av_waitrequest;
  logic        busy;
  logic        overflow;
  logic        wrapped;
  logic [24:0] words_written;

  sdram_capture_writer #(
    .BASE_ADDR  (BASE),
    .ADDR_LIMIT (LIMIT),
    .DEPTH      (DEPTH)
  ) dut (
    .M100CLK        (M100CLK),
    .reset          (reset),
    .arm            (arm),
    .sample_valid   (sample_valid),
    .sample         (sample),
    .av_chipselect  (av_chipselect),
    .av_address     (av_address),
    .av_byteenable  (av_byteenable),
    .av_writedata   (av_writedata),
    .av_write       (av_write),
    .av_waitrequest (av_waitrequest),
    .busy           (busy),
    .overflow       (overflow),
    .wrapped        (wrapped),
    .words_written  (words_written)
  );

  always #5 M100CLK = ~M100CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_half;
  logic [7:0]  m_byte;
  logic [17:0] exp_q[$];
  logic [24:0] exp_addr;
  int          n_writes;
  int          n_stalls;
  logic        held_v;
  logic [42:0] held;
  logic [17:0] mon_w;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_push(input logic [17:0] w);
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_half) begin
      m_half = 1'b1;
      m_byte = b;
    end else begin
      model_push({2'b11, b, m_byte});
      m_half = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge M100CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sample_valid = 1'b1;
    sample       = b;
    model_byte(b);
    tick();
    sample_valid = 1'b0;
    sample       = 8'h00;
  endtask

  task automatic arm_on();
    arm      = 1'b1;
    exp_addr = BASE;
    m_half   = 1'b0;
    tick();
  endtask

  task automatic arm_off();
    arm = 1'b0;
    if (m_half) begin
      model_push({2'b01, 8'h00, m_byte});
      m_half = 1'b0;
    end
    tick();
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    if (busy) check_val("drain_timeout", 64'(busy), 64'd0);
    check_val("q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: checks hold-stability under stall and every accepted word against the queue.
  always @(negedge M100CLK) begin
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (av_write && av_waitrequest) begin
        n_stalls++;
        if (held_v) check_val("hold_stable", 64'({av_address, av_writedata, av_byteenable}), 64'(held));
        held_v = 1'b1;
        held   = {av_address, av_writedata, av_byteenable};
      end else begin
        held_v = 1'b0;
      end
      if (av_write && !av_waitrequest) begin
        check_val("chipselect", 64'(av_chipselect), 64'd1);
        if (exp_q.size() == 0) begin
          check_val("unexpected_write", 64'd1, 64'd0);
        end else begin
          mon_w = exp_q.pop_front();
          check_val("wr_data", 64'(av_writedata), 64'(mon_w[15:0]));
          check_val("wr_be", 64'(av_byteenable), 64'(mon_w[17:16]));
          check_val("wr_addr", 64'(av_address), 64'(exp_addr));
        end
        exp_addr = (exp_addr == LIMIT) ? BASE : exp_addr + 25'd1;
        n_writes++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wc;
    reset = 1'b1; arm = 1'b0; sample_valid = 1'b0; sample = 8'h00; av_waitrequest = 1'b0;
    m_half = 1'b0; m_byte = 8'h00; exp_addr = BASE; n_writes = 0; n_stalls = 0;
    held_v = 1'b0; held = '0;
    repeat (3) tick();
    check_val("rst_av_write", 64'(av_write), 64'd0);
    check_val("rst_cs", 64'(av_chipselect), 64'd0);
    check_val("rst_addr", 64'(av_address), 64'(BASE));
    check_val("rst_be", 64'(av_byteenable), 64'd0);
    check_val("rst_wdata", 64'(av_writedata), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_status", 64'({overflow, wrapped}), 64'd0);
    check_val("rst_words", 64'(words_written), 64'd0);
    reset = 1'b0;
    tick();

    // single pair, write latency
    arm_on();
    check_val("busy_capture", 64'(busy), 64'd1);
    sample_valid = 1'b1; sample = 8'h11; model_byte(8'h11);
    tick();
    sample = 8'h22; model_byte(8'h22);
    check_val("pre_write", 64'(av_write), 64'd0);
    tick();
    sample_valid = 1'b0;
    check_val("write_latency", 64'(av_write), 64'd1);
    tick();
    check_val("words_one", 64'(words_written), 64'd1);
    check_val("write_done", 64'(av_write), 64'd0);
    arm_off();
    wait_idle();

    // stalled write
    arm_on();
    av_waitrequest = 1'b1;
    n_stalls = 0;
    send_byte(8'hEF);
    send_byte(8'hBE);
    repeat (5) tick();
    av_waitrequest = 1'b0;
    tick();
    check_val("stall_cycles", 64'(n_stalls), 64'd5);
    check_val("stall_words", 64'(words_written), 64'd1);
    check_val("stall_q_empty", 64'(exp_q.size()), 64'd0);
    arm_off();
    wait_idle();

    // address wrap
    arm_on();
    for (int i = 0; i < 12; i++) send_byte(8'h30 + 8'(i));
    arm_off();
    wait_idle();
    check_val("wrap_flag", 64'(wrapped), 64'd1);
    check_val("wrap_words", 64'(words_written), 64'd6);
    check_val("wrap_ovf", 64'(overflow), 64'd0);

    // overflow with slave stalled
    arm_on();
    av_waitrequest = 1'b1;
    wc = n_writes;
    for (int i = 0; i < 12; i++) send_byte(8'h80 + 8'(i));
    tick();
    check_val("ovf_flag", 64'(overflow), 64'd1);
    check_val("ovf_queued", 64'(exp_q.size()), 64'd4);
    av_waitrequest = 1'b0;
    arm_off();
    wait_idle();
    check_val("ovf_writes", 64'(n_writes - wc), 64'd4);
    check_val("ovf_words", 64'(words_written), 64'd4);
    check_val("ovf_sticky", 64'(overflow), 64'd1);

    // odd byte count, pad on drain
    arm_on();
    wc = n_writes;
    check_val("arm_clears_ovf", 64'(overflow), 64'd0);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    arm_off();
    wait_idle();
    check_val("pad_writes", 64'(n_writes - wc), 64'd2);
    check_val("pad_busy", 64'(busy), 64'd0);
    check_val("pad_words", 64'(words_written), 64'd2);

    // arm and samples ignored while draining
    arm_on();
    av_waitrequest = 1'b1;
    send_byte(8'h5A);
    send_byte(8'hA5);
    arm = 1'b0;
    tick();
    arm = 1'b1;
    sample_valid = 1'b1; sample = 8'h55;
    tick();
    sample = 8'h66;
    tick();
    sample_valid = 1'b0;
    check_val("drain_busy", 64'(busy), 64'd1);
    arm = 1'b0;
    av_waitrequest = 1'b0;
    wait_idle();
    check_val("drain_words", 64'(words_written), 64'd1);

    // reset during a stalled write
    arm_on();
    for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i));
    repeat (3) tick();
    check_val("pre_rst_wrapped", 64'(wrapped), 64'd1);
    av_waitrequest = 1'b1;
    send_byte(8'hDE);
    send_byte(8'hAD);
    check_val("pre_rst_write", 64'(av_write), 64'd1);
    reset = 1'b1;
    tick();
    check_val("mid_rst_write", 64'(av_write), 64'd0);
    check_val("mid_rst_addr", 64'(av_address), 64'(BASE));
    check_val("mid_rst_status", 64'({busy, overflow, wrapped}), 64'd0);
    check_val("mid_rst_words", 64'(words_written), 64'd0);
    exp_q.delete();
    m_half = 1'b0;
    arm = 1'b0;
    av_waitrequest = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_val("post_rst_quiet", 64'({av_write, busy}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
